// File: rtl/avr_uart_tx_pkg.sv
// Shared definitions for the AVR UART link: state encodings, frame shape and default bit period.
// The receiver side imports the same package so both ends agree on framing.
package avr_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Width of a counter that must hold 0..clks_per_bit-1.
    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/avr_uart_tx_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through: dout always shows the head entry.
// A push while full is ignored even if a pop happens on the same edge.
module byte_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_level == (FIFO_AW + 1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout = r_mem[r_rd_ptr];

endmodule

// File: rtl/avr_uart_tx.sv
// 8N1 serial transmitter towards the AVR supervisor, fed by a small byte FIFO and
// gated at frame boundaries by the AVR's synchronised busy flag.
module avr_uart_tx
    import avr_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 3
) (
    input  logic               sysclk,
    input  logic               sysrst,
    input  logic [7:0]         wr_data,
    input  logic               wr_en,
    output logic               full,
    output logic [FIFO_AW:0]   level,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic               tx_active,
    input  logic               avr_rx_busy,
    output logic               avr_rx
);

    localparam int             TW       = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t      r_state;
    tx_state_t      w_state_next;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timer_next;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_next;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic           r_avr_rx;
    logic           w_avr_rx_next;
    logic           r_busy_meta;
    logic           r_busy_s;
    logic           r_overflow;

    logic           w_pop;
    logic           w_bit_done;
    logic           w_can_start;
    logic [7:0]     w_fifo_dout;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [FIFO_AW:0] w_fifo_level;

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (sysclk),
        .srst  (sysrst),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    // Busy resets to 1 so nothing starts until the AVR has been seen idle for two edges.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_busy_meta <= 1'b1;
            r_busy_s    <= 1'b1;
        end else begin
            r_busy_meta <= avr_rx_busy;
            r_busy_s    <= r_busy_meta;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_bit_done  = (r_timer == BIT_LAST);
    assign w_can_start = !w_fifo_empty && !r_busy_s;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_avr_rx_next  = r_avr_rx;
        w_pop          = 1'b0;
        w_timer_next   = (r_state == IDLE || w_bit_done) ? '0 : r_timer + 1'b1;

        case (r_state)
            IDLE: begin
                w_avr_rx_next = 1'b1;
                if (w_can_start) begin
                    w_state_next  = START;
                    w_pop         = 1'b1;
                    w_shift_next  = w_fifo_dout;
                    w_avr_rx_next = 1'b0;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                    w_avr_rx_next  = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_next  = STOP;
                        w_avr_rx_next = 1'b1;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_avr_rx_next  = r_shift[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes go out back-to-back.
                if (w_bit_done) begin
                    if (w_can_start) begin
                        w_state_next  = START;
                        w_pop         = 1'b1;
                        w_shift_next  = w_fifo_dout;
                        w_avr_rx_next = 1'b0;
                    end else begin
                        w_state_next  = IDLE;
                        w_avr_rx_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_avr_rx_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_avr_rx  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_avr_rx  <= w_avr_rx_next;
        end
    end

    assign avr_rx    = r_avr_rx;
    assign tx_active = (r_state != IDLE);
    assign full      = w_fifo_full;
    assign level     = w_fifo_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_avr_uart_tx.sv
// Bench for avr_uart_tx: stimulus queues expected bytes, a monitor derives line timing
// from frame arithmetic and checks every cycle plus each decoded byte.
module tb_avr_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic          sysclk      = 1'b0;
    logic          sysrst      = 1'b1;
    logic [7:0]    wr_data     = 8'h00;
    logic          wr_en       = 1'b0;
    logic          ovf_clr     = 1'b0;
    logic          avr_rx_busy = 1'b1;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic          tx_active;
    logic          avr_rx;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];
    bit            push_pending = 1'b0;
    bit            m_in_frame   = 1'b0;
    logic          busy_req     = 1'b1;

    always #5 sysclk = ~sysclk;

    avr_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .sysclk      (sysclk),
        .sysrst      (sysrst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .tx_active   (tx_active),
        .avr_rx_busy (avr_rx_busy),
        .avr_rx      (avr_rx)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; a write is queued as expected output only if the FIFO has room.
    task automatic step(input logic we, input logic [7:0] d, input logic clr, input logic rst);
        @(negedge sysclk);
        wr_en       = we;
        wr_data     = d;
        ovf_clr     = clr;
        sysrst      = rst;
        avr_rx_busy = busy_req;
        if (we && !rst) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(d);
                push_pending = 1'b1;
                $display("wr 0x%02h accepted, queued=%0d", d, exp_q.size());
            end else begin
                $display("wr 0x%02h dropped (full)", d);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: frame start rule = line free, bytes waiting before this edge, busy_s clear.
    initial begin : monitor
        int         cyc;
        int         s_cyc;
        int         el;
        int         n;
        int         lvl_before;
        bit         started;
        bit         busy_s_prev;
        bit         exp_ovf;
        logic       eff1, eff2, rst1;
        logic       exp_rx;
        logic [7:0] cur;
        logic [7:0] rx_bits;
        cyc = 0; s_cyc = 0; started = 1'b0; exp_ovf = 1'b0;
        eff1 = 1'b1; eff2 = 1'b1; rst1 = 1'b1;
        cur = 8'h00; rx_bits = 8'h00;
        forever begin
            @(posedge sysclk);
            #1;
            cyc++;
            if (sysrst) begin
                started      = 1'b1;
                exp_q.delete();
                m_in_frame   = 1'b0;
                exp_ovf      = 1'b0;
                push_pending = 1'b0;
            end else if (started) begin
                lvl_before  = exp_q.size() - (push_pending ? 1 : 0);
                busy_s_prev = rst1 ? 1'b1 : eff2;
                if (m_in_frame && (cyc - s_cyc) == FRAME) m_in_frame = 1'b0;
                if (!m_in_frame && lvl_before > 0 && !busy_s_prev) begin
                    m_in_frame = 1'b1;
                    s_cyc      = cyc;
                    cur        = exp_q.pop_front();
                    rx_bits    = 8'h00;
                end
                if (wr_en && lvl_before == DEPTH) exp_ovf = 1'b1;
                else if (ovf_clr)                 exp_ovf = 1'b0;
                push_pending = 1'b0;
            end
            eff2 = eff1;
            eff1 = sysrst ? 1'b1 : avr_rx_busy;
            rst1 = sysrst;

            if (started) begin
                exp_rx = 1'b1;
                if (m_in_frame) begin
                    el = cyc - s_cyc;
                    n  = el / CPB;
                    if (n == 0)      exp_rx = 1'b0;
                    else if (n <= 8) exp_rx = cur[n-1];
                    if (el % CPB == CPB / 2 && n >= 1 && n <= 8) rx_bits[n-1] = avr_rx;
                    if (el == 9 * CPB + CPB / 2) begin
                        $display("rx byte 0x%02h (expected 0x%02h)", rx_bits, cur);
                        check("byte_rx", int'(rx_bits), int'(cur));
                    end
                end
                check("avr_rx",    int'(avr_rx),    int'(exp_rx));
                check("tx_active", int'(tx_active), int'(m_in_frame));
                check("level",     int'(level),     exp_q.size());
                check("full",      int'(full),      (exp_q.size() == DEPTH) ? 1 : 0);
                check("overflow",  int'(overflow),  int'(exp_ovf));
            end
        end
    end

    initial begin : stimulus
        int waited;
        busy_req = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
        busy_req = 1'b0;
        idle(4);

        // Single byte
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(FRAME + 10);

        // Burst to full, one dropped write, then back-to-back drain and overflow clear
        busy_req = 1'b1;
        idle(3);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        idle(3);
        busy_req = 1'b0;
        idle(8 * FRAME + 10);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Full FIFO with writes on every cycle across the first pop edge
        busy_req = 1'b1;
        idle(3);
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        busy_req = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(8 * FRAME + 20);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flow control: held by busy, then busy asserted mid-frame
        busy_req = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        idle(10);
        busy_req = 1'b0;
        idle(15);
        busy_req = 1'b1;
        step(1'b1, 8'h81, 1'b0, 1'b0);
        idle(2 * FRAME);
        busy_req = 1'b0;
        idle(FRAME + 10);

        // Reset in the middle of the data bits, then a clean frame
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        idle(5 * CPB + 2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(4);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle(FRAME + 10);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) busy_req = ~busy_req;
            step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1499) == 0) ? 1'b1 : 1'b0);
        end

        busy_req = 1'b0;
        waited = 0;
        while ((exp_q.size() != 0 || m_in_frame) && waited < 2000) begin
            idle(1);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0 || m_in_frame) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes still queued after %0d cycles", exp_q.size(), waited);
        end
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
